// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared fetch-stage types, reset PC and exception codes
package pc_fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: request/grant/response instruction memory port
interface pc_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/pc_fetch_unit_if_id_reg.sv
// pc_fetch_unit_if_id_reg: IF/ID pipeline register with stall hold and bubble insertion
module pc_fetch_unit_if_id_reg
  import pc_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid,
  output logic        exc_adel
);
  logic [31:0] instr_q, instr_d, pc_q, pc_d;
  logic        valid_q, valid_d, exc_q, exc_d;
  logic        take;
  assign take = !stall && load;
  always_comb begin
    instr_d = take ? instr_in : instr_q;
    pc_d    = take ? pc_in : pc_q;
    exc_d   = take ? pc_misaligned(pc_in) : exc_q;
    valid_d = stall ? valid_q : load;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
    end
  end
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign valid    = valid_q;
  assign exc_adel = exc_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds fetch PC, fetches words over a req/gnt/rvalid port,
// and hands instruction plus PC to decode through the IF/ID register.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            npc,
  input  logic                   stall_d,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            pc_f,
  output logic [31:0]            instr_d,
  output logic [31:0]            pc_d,
  output logic                   valid_d,
  output logic                   exc_adel_d
);
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d, hold_q, hold_d, load_instr;
  logic         load;
  always_comb begin
    state_d = state_q;
    pc_f_d  = pc_f_q;
    hold_d  = hold_q;
    load    = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem.gnt) state_d = WAIT;
      WAIT: if (imem.rvalid) begin
        if (stall_d) begin
          hold_d  = imem.rdata;
          state_d = HOLD;
        end else begin
          load    = 1'b1;
          pc_f_d  = npc;
          state_d = REQ;
        end
      end
      HOLD: if (!stall_d) begin
        load    = 1'b1;
        pc_f_d  = npc;
        state_d = REQ;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_f_q  <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      hold_q  <= hold_d;
    end
  end
  assign load_instr = (state_q == HOLD) ? hold_q : imem.rdata;
  assign imem.req   = (state_q == REQ);
  assign imem.addr  = {pc_f_q[31:2], 2'b00};
  assign pc_f       = pc_f_q;
  pc_fetch_unit_if_id_reg u_if_id (
    .clk      (clk),
    .reset_n  (reset_n),
    .stall    (stall_d),
    .load     (load),
    .instr_in (load_instr),
    .pc_in    (pc_f_q),
    .instr    (instr_d),
    .pc       (pc_d),
    .valid    (valid_d),
    .exc_adel (exc_adel_d)
  );
  // read data may only arrive while a granted request is outstanding
  rvalid_in_wait_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(imem.rvalid && (state_q == REQ || state_q == HOLD)));
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plus randomized fetch traffic against an
// instruction-stream reference model of the fetch unit.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;
  localparam logic [31:0] RPC = RESET_PC_DEFAULT;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_d = 1'b0;
  logic [31:0] npc = '0;
  logic [31:0] pc_f, instr_d, pc_d;
  logic        valid_d, exc_adel_d;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mpc, m_instr, m_pc;
  logic        m_valid, m_exc;
  pc_fetch_unit_if imem ();
  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .npc        (npc),
    .stall_d    (stall_d),
    .imem       (imem.master),
    .pc_f       (pc_f),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .valid_d    (valid_d),
    .exc_adel_d (exc_adel_d)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_pc_f", pc_f, RPC);
    chk("rst_req", imem.req, 0);
    chk("rst_addr", imem.addr, RPC);
    chk("rst_valid_d", valid_d, 0);
    chk("rst_instr_d", instr_d, 0);
    chk("rst_pc_d", pc_d, 0);
    chk("rst_exc", exc_adel_d, 0);
  endtask
  task automatic model_reset();
    mpc = RPC; m_instr = '0; m_pc = '0; m_valid = 1'b0; m_exc = 1'b0;
  endtask
  // one clock: model the IF/ID rules, then compare the decode-side outputs
  task automatic tick(input logic dlv, input logic [31:0] din);
    if (!stall_d) begin
      if (dlv) begin
        m_valid = 1'b1; m_instr = din; m_pc = mpc; m_exc = (mpc[1:0] != 2'b00);
      end else m_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("valid_d", valid_d, m_valid);
    chk("instr_d", instr_d, m_instr);
    chk("pc_d", pc_d, m_pc);
    chk("exc_adel_d", exc_adel_d, m_exc);
  endtask
  // one fetch starting in the request phase: gd cycles before grant, rd idle
  // cycles before data, st stall cycles from data arrival, nxt offered on advance
  task automatic xfer(input int gd, input int rd, input int st, input logic [31:0] nxt, input logic [31:0] data);
    for (int i = 0; i < gd; i++) begin
      chk("req_wait_gnt", imem.req, 1);
      chk("addr_wait_gnt", imem.addr, {mpc[31:2], 2'b00});
      imem.gnt = 1'b0; npc = $urandom;
      tick(1'b0, '0);
      chk("pc_f_req", pc_f, mpc);
    end
    chk("req", imem.req, 1);
    chk("addr", imem.addr, {mpc[31:2], 2'b00});
    imem.gnt = 1'b1; npc = $urandom;
    tick(1'b0, '0);
    imem.gnt = 1'b0;
    chk("req_dropped", imem.req, 0);
    chk("pc_f_gnt", pc_f, mpc);
    for (int i = 0; i < rd; i++) begin
      imem.gnt = 1'($urandom); stall_d = (st > 0); npc = $urandom;
      tick(1'b0, '0);
      chk("pc_f_wait", pc_f, mpc);
    end
    imem.gnt = 1'b0;
    imem.rvalid = 1'b1; imem.rdata = data;
    if (st == 0) begin
      stall_d = 1'b0; npc = nxt;
      tick(1'b1, data);
    end else begin
      stall_d = 1'b1; npc = $urandom;
      tick(1'b0, '0);
      chk("pc_f_stall", pc_f, mpc);
      imem.rvalid = 1'b0; imem.rdata = $urandom;
      for (int i = 1; i < st; i++) begin
        imem.gnt = 1'($urandom); npc = $urandom;
        tick(1'b0, '0);
        chk("pc_f_hold", pc_f, mpc);
      end
      imem.gnt = 1'b0; stall_d = 1'b0; npc = nxt;
      tick(1'b1, data);
    end
    imem.rvalid = 1'b0; stall_d = 1'b0; npc = $urandom;
    mpc = nxt;
    chk("pc_f_adv", pc_f, mpc);
    chk("req_next", imem.req, 1);
  endtask
  initial begin
    logic [31:0] nxt;
    int r, st;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    model_reset();
    #12;
    chk_reset();
    @(negedge clk); reset_n = 1'b1;
    tick(1'b0, '0);
    chk("pc_f_idle", pc_f, RPC);
    // sequential stream, best-case timing
    for (int i = 0; i < 3; i++) xfer(0, 0, 0, mpc + 4, {mpc[15:0], ~mpc[15:0]});
    xfer(3, 0, 0, mpc + 4, 32'hA5A5_0003);
    xfer(0, 1, 3, mpc + 4, 32'h1234_5678);
    xfer(0, 2, 0, 32'h0000_3100, 32'h0BAD_CAFE);
    xfer(1, 0, 0, 32'h0000_3102, 32'h0000_3100);
    xfer(0, 0, 0, 32'h0000_3108, 32'h0000_3102);
    xfer(0, 0, 2, 32'hFFFF_FFFC, 32'h0000_3108);
    xfer(0, 0, 0, 32'h0000_0000, 32'hFFFF_0000);
    xfer(0, 0, 0, 32'h0000_0004, 32'h1111_2222);
    // reset asserted while waiting for read data
    imem.gnt = 1'b1;
    tick(1'b0, '0);
    imem.gnt = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk_reset();
    @(negedge clk); reset_n = 1'b1;
    imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
    tick(1'b0, '0);
    imem.rvalid = 1'b0;
    chk("pc_f_after_reset", pc_f, RPC);
    xfer(0, 0, 0, mpc + 4, 32'h5555_AAAA);
    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      nxt = (r < 6) ? mpc + 4 : (r < 8) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      xfer($urandom_range(0, 3), $urandom_range(0, 2), st, nxt, $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
